// File: rtl/rv32_regs_ctrl_if.sv
// Debug requester bus for rv32_regs_ctrl: a valid/ready request channel
// (read or write of one register) plus a one-cycle completion pulse with
// read data. The controller side uses the slave modport.
interface rv32_regs_ctrl_if;
    logic        dbg_valid_in;
    logic        dbg_write_in;
    logic [4:0]  dbg_addr_in;
    logic [31:0] dbg_wdata_in;
    logic        dbg_ready_out;
    logic        dbg_done_out;
    logic [31:0] dbg_rdata_out;

    modport master (
        output dbg_valid_in,
        output dbg_write_in,
        output dbg_addr_in,
        output dbg_wdata_in,
        input  dbg_ready_out,
        input  dbg_done_out,
        input  dbg_rdata_out
    );

    modport slave (
        input  dbg_valid_in,
        input  dbg_write_in,
        input  dbg_addr_in,
        input  dbg_wdata_in,
        output dbg_ready_out,
        output dbg_done_out,
        output dbg_rdata_out
    );
endinterface

// File: rtl/rv32_regs_ctrl.sv
// Port controller / arbiter in front of the rv32_regs register file.
// Clears x1..x31 after reset, then passes pipeline traffic through and lets
// a debug requester borrow the write port (idle writeback slot) or read
// port 1 (pipeline frozen, operands re-read the following cycle).
module rv32_regs_ctrl (
    input  logic                   clk,
    input  logic                   reset_n,

    // pipeline side
    input  logic                   pipe_stall_in,
    input  logic [4:0]             pipe_rs1_in,
    input  logic [4:0]             pipe_rs2_in,
    input  logic [4:0]             pipe_rd_in,
    input  logic                   pipe_rd_writeback_in,
    input  logic [31:0]            pipe_rd_value_in,
    output logic                   pipe_hold_out,
    output logic                   init_done_out,

    // debug requester
    rv32_regs_ctrl_if.slave        dbg,

    // register file side
    output logic                   regs_stall_out,
    output logic [4:0]             regs_rs1_out,
    output logic [4:0]             regs_rs2_out,
    output logic [4:0]             regs_rd_out,
    output logic                   regs_rd_writeback_out,
    output logic [31:0]            regs_rd_value_out,
    input  logic [31:0]            regs_rs1_value_in
);

    typedef enum logic [1:0] {
        CLEAR       = 2'd0,
        IDLE        = 2'd1,
        DBG_RESTORE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  clr_cnt;
    logic [4:0]  clr_cnt_nxt;
    logic        init_done;
    logic        init_done_nxt;
    logic        dbg_done;
    logic        dbg_done_nxt;
    logic [31:0] dbg_rdata;
    logic [31:0] dbg_rdata_nxt;

    logic        dbg_ready;
    logic        dbg_accept;
    logic        dbg_wr_accept;
    logic        dbg_rd_accept;

    // Debug may only go when the pipeline is frozen and not using the
    // write port, so a debug access never collides with pipeline traffic.
    assign dbg_ready     = (state == IDLE) && pipe_stall_in && !pipe_rd_writeback_in;
    assign dbg_accept    = dbg_ready && dbg.dbg_valid_in;
    assign dbg_wr_accept = dbg_accept && dbg.dbg_write_in;
    assign dbg_rd_accept = dbg_accept && !dbg.dbg_write_in;

    assign dbg.dbg_ready_out = dbg_ready;
    assign dbg.dbg_done_out  = dbg_done;
    assign dbg.dbg_rdata_out = dbg_rdata;
    assign init_done_out     = init_done;

    // State, clear counter and registered debug/status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= CLEAR;
            clr_cnt   <= 5'd1;
            init_done <= 1'b0;
            dbg_done  <= 1'b0;
            dbg_rdata <= 32'd0;
        end else begin
            state     <= state_nxt;
            clr_cnt   <= clr_cnt_nxt;
            init_done <= init_done_nxt;
            dbg_done  <= dbg_done_nxt;
            dbg_rdata <= dbg_rdata_nxt;
        end
    end

    // Next-state logic and register-file port steering.
    always_comb begin
        state_nxt             = state;
        clr_cnt_nxt           = clr_cnt;
        init_done_nxt         = init_done;
        dbg_done_nxt          = 1'b0;
        dbg_rdata_nxt         = dbg_rdata;

        pipe_hold_out         = 1'b0;
        regs_stall_out        = pipe_stall_in;
        regs_rs1_out          = pipe_rs1_in;
        regs_rs2_out          = pipe_rs2_in;
        regs_rd_out           = pipe_rd_in;
        regs_rd_writeback_out = pipe_rd_writeback_in;
        regs_rd_value_out     = pipe_rd_value_in;

        case (state)
            CLEAR: begin
                // One register per cycle; pipeline writeback is dropped.
                pipe_hold_out         = 1'b1;
                regs_stall_out        = 1'b1;
                regs_rd_out           = clr_cnt;
                regs_rd_writeback_out = 1'b1;
                regs_rd_value_out     = 32'd0;
                clr_cnt_nxt           = clr_cnt + 5'd1;
                if (clr_cnt == 5'd31) begin
                    state_nxt     = IDLE;
                    init_done_nxt = 1'b1;
                end
            end

            IDLE: begin
                if (dbg_wr_accept) begin
                    // Writes to x0 still complete but never strobe the file.
                    regs_rd_out           = dbg.dbg_addr_in;
                    regs_rd_value_out     = dbg.dbg_wdata_in;
                    regs_rd_writeback_out = (dbg.dbg_addr_in != 5'd0);
                    dbg_done_nxt          = 1'b1;
                end else if (dbg_rd_accept) begin
                    // Unfreeze the file for one cycle to latch the debug
                    // address on port 1; port 2 keeps the pipeline operand.
                    pipe_hold_out  = 1'b1;
                    regs_stall_out = 1'b0;
                    regs_rs1_out   = dbg.dbg_addr_in;
                    state_nxt      = DBG_RESTORE;
                end
            end

            DBG_RESTORE: begin
                // Capture the debug read, and re-read the pipeline operands
                // so they are back in the file's output registers.
                pipe_hold_out  = 1'b1;
                regs_stall_out = 1'b0;
                dbg_rdata_nxt  = regs_rs1_value_in;
                dbg_done_nxt   = 1'b1;
                state_nxt      = IDLE;
            end

            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

endmodule

// File: tb/tb_rv32_regs_ctrl.sv
// Directed testbench for rv32_regs_ctrl with a small behavioural register
// file (registered reads, stall holds the read outputs).
module tb_rv32_regs_ctrl;

    logic        clk;
    logic        reset_n;
    logic        pipe_stall_in;
    logic [4:0]  pipe_rs1_in;
    logic [4:0]  pipe_rs2_in;
    logic [4:0]  pipe_rd_in;
    logic        pipe_rd_writeback_in;
    logic [31:0] pipe_rd_value_in;
    logic        pipe_hold_out;
    logic        init_done_out;
    logic        regs_stall_out;
    logic [4:0]  regs_rs1_out;
    logic [4:0]  regs_rs2_out;
    logic [4:0]  regs_rd_out;
    logic        regs_rd_writeback_out;
    logic [31:0] regs_rd_value_out;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    int checks = 0;
    int errors = 0;

    rv32_regs_ctrl_if dbg_bus ();

    rv32_regs_ctrl dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .pipe_stall_in         (pipe_stall_in),
        .pipe_rs1_in           (pipe_rs1_in),
        .pipe_rs2_in           (pipe_rs2_in),
        .pipe_rd_in            (pipe_rd_in),
        .pipe_rd_writeback_in  (pipe_rd_writeback_in),
        .pipe_rd_value_in      (pipe_rd_value_in),
        .pipe_hold_out         (pipe_hold_out),
        .init_done_out         (init_done_out),
        .dbg                   (dbg_bus),
        .regs_stall_out        (regs_stall_out),
        .regs_rs1_out          (regs_rs1_out),
        .regs_rs2_out          (regs_rs2_out),
        .regs_rd_out           (regs_rd_out),
        .regs_rd_writeback_out (regs_rd_writeback_out),
        .regs_rd_value_out     (regs_rd_value_out),
        .regs_rs1_value_in     (rs1_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file: raw storage (x0 included, so a stray x0
    // write is visible), seeded with junk so the clear is observable.
    logic [31:0] rf [32];
    logic        rf_seeded = 1'b0;

    always @(posedge clk) begin
        if (!rf_seeded) begin
            for (int i = 0; i < 32; i++)
                rf[i] <= (i == 0) ? 32'd0 : (32'hBAD0_0000 | 32'(i));
            rf_seeded <= 1'b1;
        end else if (regs_rd_writeback_out) begin
            rf[regs_rd_out] <= regs_rd_value_out;
        end
        if (!regs_stall_out) begin
            rs1_val <= rf[regs_rs1_out];
            rs2_val <= rf[regs_rs2_out];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at the negedge where reset_n was just released; walks the
    // 31 clear cycles and ends one cycle after, with init_done expected.
    task automatic run_clear_checks();
        for (int i = 1; i <= 31; i++) begin
            #1;
            check("clr_rd",   {27'd0, regs_rd_out}, 32'(i));
            check("clr_wb",   {31'd0, regs_rd_writeback_out}, 32'd1);
            check("clr_val",  regs_rd_value_out, 32'd0);
            check("clr_hold", {31'd0, pipe_hold_out}, 32'd1);
            check("clr_init", {31'd0, init_done_out}, 32'd0);
            check("clr_done", {31'd0, dbg_bus.dbg_done_out}, 32'd0);
            @(negedge clk);
        end
        #1;
        check("init_done", {31'd0, init_done_out}, 32'd1);
        check("init_hold", {31'd0, pipe_hold_out}, 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n              = 1'b0;
        pipe_stall_in        = 1'b0;
        pipe_rs1_in          = 5'd0;
        pipe_rs2_in          = 5'd0;
        pipe_rd_in           = 5'd7;
        pipe_rd_writeback_in = 1'b1;
        pipe_rd_value_in     = 32'h0000_FFFF;
        dbg_bus.dbg_valid_in = 1'b0;
        dbg_bus.dbg_write_in = 1'b0;
        dbg_bus.dbg_addr_in  = 5'd0;
        dbg_bus.dbg_wdata_in = 32'd0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_init",  {31'd0, init_done_out}, 32'd0);
        check("rst_ready", {31'd0, dbg_bus.dbg_ready_out}, 32'd0);
        check("rst_done",  {31'd0, dbg_bus.dbg_done_out}, 32'd0);
        check("rst_rdata", dbg_bus.dbg_rdata_out, 32'd0);
        check("rst_hold",  {31'd0, pipe_hold_out}, 32'd1);
        check("rst_stall", {31'd0, regs_stall_out}, 32'd1);

        // Clear sequence with pipeline writeback being ignored
        @(negedge clk);
        reset_n = 1'b1;
        run_clear_checks();
        pipe_rd_writeback_in = 1'b0;
        check("x31_clr", rf[31], 32'd0);
        check("x7_clr",  rf[7],  32'd0);

        // Debug write x5 = DEADBEEF
        @(negedge clk);
        pipe_stall_in        = 1'b1;
        dbg_bus.dbg_valid_in = 1'b1;
        dbg_bus.dbg_write_in = 1'b1;
        dbg_bus.dbg_addr_in  = 5'd5;
        dbg_bus.dbg_wdata_in = 32'hDEAD_BEEF;
        #1;
        check("dw_ready", {31'd0, dbg_bus.dbg_ready_out}, 32'd1);
        check("dw_rd",    {27'd0, regs_rd_out}, 32'd5);
        check("dw_wb",    {31'd0, regs_rd_writeback_out}, 32'd1);
        check("dw_val",   regs_rd_value_out, 32'hDEAD_BEEF);
        check("dw_hold",  {31'd0, pipe_hold_out}, 32'd0);
        @(negedge clk);
        dbg_bus.dbg_valid_in = 1'b0;
        #1;
        check("dw_done", {31'd0, dbg_bus.dbg_done_out}, 32'd1);
        @(negedge clk);
        pipe_stall_in = 1'b0;
        pipe_rs1_in   = 5'd5;
        #1;
        check("dw_done_clr", {31'd0, dbg_bus.dbg_done_out}, 32'd0);
        @(negedge clk);
        #1;
        check("x5_pipe_rd", rs1_val, 32'hDEAD_BEEF);

        // Debug write to x0 is dropped
        @(negedge clk);
        pipe_stall_in        = 1'b1;
        dbg_bus.dbg_valid_in = 1'b1;
        dbg_bus.dbg_write_in = 1'b1;
        dbg_bus.dbg_addr_in  = 5'd0;
        dbg_bus.dbg_wdata_in = 32'h1234_5678;
        #1;
        check("dw0_ready", {31'd0, dbg_bus.dbg_ready_out}, 32'd1);
        check("dw0_wb",    {31'd0, regs_rd_writeback_out}, 32'd0);
        @(negedge clk);
        dbg_bus.dbg_valid_in = 1'b0;
        #1;
        check("dw0_done", {31'd0, dbg_bus.dbg_done_out}, 32'd1);
        @(negedge clk);
        pipe_stall_in = 1'b0;
        pipe_rs1_in   = 5'd0;
        @(negedge clk);
        #1;
        check("x0_pipe_rd", rs1_val, 32'd0);

        // Pipeline writes x3/x4 and holds them as operands
        @(negedge clk);
        pipe_rd_writeback_in = 1'b1;
        pipe_rd_in           = 5'd3;
        pipe_rd_value_in     = 32'h11;
        @(negedge clk);
        pipe_rd_in           = 5'd4;
        pipe_rd_value_in     = 32'h22;
        @(negedge clk);
        pipe_rd_writeback_in = 1'b0;
        pipe_rs1_in          = 5'd3;
        pipe_rs2_in          = 5'd4;
        @(negedge clk);
        #1;
        check("op_rs1", rs1_val, 32'h11);
        check("op_rs2", rs2_val, 32'h22);

        // Debug read of x5, cycle T
        pipe_stall_in        = 1'b1;
        dbg_bus.dbg_valid_in = 1'b1;
        dbg_bus.dbg_write_in = 1'b0;
        dbg_bus.dbg_addr_in  = 5'd5;
        #1;
        check("dr_ready",    {31'd0, dbg_bus.dbg_ready_out}, 32'd1);
        check("dr_T_hold",   {31'd0, pipe_hold_out}, 32'd1);
        check("dr_T_stall",  {31'd0, regs_stall_out}, 32'd0);
        check("dr_T_rs1",    {27'd0, regs_rs1_out}, 32'd5);
        check("dr_T_rs2",    {27'd0, regs_rs2_out}, 32'd4);
        // T+1: pipeline writes x5, which must not reach the read result
        @(negedge clk);
        dbg_bus.dbg_valid_in = 1'b0;
        pipe_rd_writeback_in = 1'b1;
        pipe_rd_in           = 5'd5;
        pipe_rd_value_in     = 32'h0000_CAFE;
        #1;
        check("dr_T1_hold",  {31'd0, pipe_hold_out}, 32'd1);
        check("dr_T1_stall", {31'd0, regs_stall_out}, 32'd0);
        check("dr_T1_rs1",   {27'd0, regs_rs1_out}, 32'd3);
        check("dr_T1_rs2",   {27'd0, regs_rs2_out}, 32'd4);
        check("dr_T1_wb",    {31'd0, regs_rd_writeback_out}, 32'd1);
        check("dr_T1_done",  {31'd0, dbg_bus.dbg_done_out}, 32'd0);
        // T+2
        @(negedge clk);
        pipe_rd_writeback_in = 1'b0;
        #1;
        check("dr_done",     {31'd0, dbg_bus.dbg_done_out}, 32'd1);
        check("dr_rdata",    dbg_bus.dbg_rdata_out, 32'hDEAD_BEEF);
        check("dr_T2_hold",  {31'd0, pipe_hold_out}, 32'd0);
        check("dr_rest_rs1", rs1_val, 32'h11);
        check("dr_rest_rs2", rs2_val, 32'h22);
        @(negedge clk);
        #1;
        check("dr_done_clr", {31'd0, dbg_bus.dbg_done_out}, 32'd0);
        check("dr_rdata_hold", dbg_bus.dbg_rdata_out, 32'hDEAD_BEEF);

        // Pipeline writeback beats a pending debug write
        @(negedge clk);
        pipe_rd_writeback_in = 1'b1;
        pipe_rd_in           = 5'd6;
        pipe_rd_value_in     = 32'h66;
        dbg_bus.dbg_valid_in = 1'b1;
        dbg_bus.dbg_write_in = 1'b1;
        dbg_bus.dbg_addr_in  = 5'd7;
        dbg_bus.dbg_wdata_in = 32'h77;
        #1;
        check("arb_ready0", {31'd0, dbg_bus.dbg_ready_out}, 32'd0);
        check("arb_rd0",    {27'd0, regs_rd_out}, 32'd6);
        check("arb_val0",   regs_rd_value_out, 32'h66);
        @(negedge clk);
        pipe_rd_writeback_in = 1'b0;
        #1;
        check("arb_ready1", {31'd0, dbg_bus.dbg_ready_out}, 32'd1);
        check("arb_rd1",    {27'd0, regs_rd_out}, 32'd7);
        check("arb_done_early", {31'd0, dbg_bus.dbg_done_out}, 32'd0);
        @(negedge clk);
        dbg_bus.dbg_valid_in = 1'b0;
        #1;
        check("arb_done", {31'd0, dbg_bus.dbg_done_out}, 32'd1);
        @(negedge clk);
        pipe_stall_in = 1'b0;
        pipe_rs1_in   = 5'd6;
        pipe_rs2_in   = 5'd7;
        @(negedge clk);
        #1;
        check("arb_x6", rs1_val, 32'h66);
        check("arb_x7", rs2_val, 32'h77);

        // Debug request without pipeline stall is not accepted
        @(negedge clk);
        dbg_bus.dbg_valid_in = 1'b1;
        dbg_bus.dbg_write_in = 1'b1;
        #1;
        check("nostall_ready", {31'd0, dbg_bus.dbg_ready_out}, 32'd0);
        dbg_bus.dbg_valid_in = 1'b0;

        // Reset pulsed mid-clear at counter 10
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (9) @(negedge clk);
        #1;
        check("mid_clr_rd10", {27'd0, regs_rd_out}, 32'd10);
        reset_n = 1'b0;
        #1;
        check("mid_clr_rd1",  {27'd0, regs_rd_out}, 32'd1);
        check("mid_clr_init", {31'd0, init_done_out}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_clear_checks();

        // Reset pulsed during DBG_RESTORE
        @(negedge clk);
        pipe_stall_in        = 1'b1;
        dbg_bus.dbg_valid_in = 1'b1;
        dbg_bus.dbg_write_in = 1'b0;
        dbg_bus.dbg_addr_in  = 5'd6;
        #1;
        check("rr_ready", {31'd0, dbg_bus.dbg_ready_out}, 32'd1);
        @(negedge clk);
        dbg_bus.dbg_write_in = 1'b1;
        #1;
        check("rr_busy_ready", {31'd0, dbg_bus.dbg_ready_out}, 32'd0);
        check("rr_busy_hold",  {31'd0, pipe_hold_out}, 32'd1);
        reset_n = 1'b0;
        dbg_bus.dbg_valid_in = 1'b0;
        #1;
        check("rr_rst_stall", {31'd0, regs_stall_out}, 32'd1);
        check("rr_rst_rd",    {27'd0, regs_rd_out}, 32'd1);
        check("rr_rst_done",  {31'd0, dbg_bus.dbg_done_out}, 32'd0);
        check("rr_rst_rdata", dbg_bus.dbg_rdata_out, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_clear_checks();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
